// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared state type and default geometry for the frame sequencer
package frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK,
        DONE
    } seq_state_t;

    localparam int DEF_CW         = 16;
    localparam int DEF_WIDTH      = 640;
    localparam int DEF_HEIGHT     = 480;
    localparam int DEF_HBLANK_CYC = 4;
    localparam int DEF_VBLANK_CYC = 16;

    localparam int DEF_LAST_COL = DEF_WIDTH - 1;
    localparam int DEF_LAST_ROW = DEF_HEIGHT - 1;

    function automatic int last_index(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/blank_timer.sv
// rtl/blank_timer.sv - loadable down-counter timing the horizontal and vertical blanking intervals
module blank_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         first_cycle,
    output logic         expire
);

    logic [W-1:0] count;

    // Loading value-1 makes expire mark the last of load_value cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            first_cycle <= 1'b0;
        end else if (load) begin
            count       <= load_value - W'(1);
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
            if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - pixel stream sequencer producing en/hsync/vsync strobes with blanking
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int HBLANK_CYC = DEF_HBLANK_CYC,
    parameter int VBLANK_CYC = DEF_VBLANK_CYC,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] num_frames,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic [CW-1:0] frame_cnt
);

    localparam logic [CW-1:0] LAST_COL    = CW'(last_index(WIDTH));
    localparam logic [CW-1:0] LAST_ROW    = CW'(last_index(HEIGHT));
    localparam logic [CW-1:0] HBLANK_LOAD = CW'(HBLANK_CYC);
    localparam logic [CW-1:0] VBLANK_LOAD = CW'(VBLANK_CYC);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic          stop_q;
    logic [CW-1:0] nframes_q;

    logic          handshake;
    logic          last_col;
    logic          last_row;
    logic          run_complete;

    logic          timer_load;
    logic [CW-1:0] timer_value;
    logic          timer_first;
    logic          timer_expire;

    assign pix_ready = (state_q == ACTIVE);
    assign busy      = (state_q != IDLE);
    assign handshake = pix_valid && pix_ready;
    assign last_col  = (col == LAST_COL);
    assign last_row  = (row == LAST_ROW);

    // A stop arriving on the final VBLANK cycle still ends the run at this frame.
    assign run_complete = stop_q || stop ||
                          ((nframes_q != '0) && ((frame_cnt + CW'(1)) == nframes_q));

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (handshake && last_col) begin
                    timer_load = 1'b1;
                    state_d    = last_row ? VBLANK : HBLANK;
                end
            end
            HBLANK: begin
                if (timer_expire) begin
                    state_d = ACTIVE;
                end
            end
            VBLANK: begin
                if (timer_expire) begin
                    state_d = run_complete ? DONE : ACTIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timer_value = (state_d == VBLANK) ? VBLANK_LOAD : HBLANK_LOAD;

    blank_timer #(
        .W (CW)
    ) u_blank_timer (
        .clk         (clk),
        .reset       (reset),
        .load        (timer_load),
        .load_value  (timer_value),
        .first_cycle (timer_first),
        .expire      (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            stop_q    <= 1'b0;
            nframes_q <= '0;
            col       <= '0;
            row       <= '0;
            frame_cnt <= '0;
            en        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            en      <= 1'b0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            done    <= (state_d == DONE);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        nframes_q <= num_frames;
                        col       <= '0;
                        row       <= '0;
                        frame_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (handshake) begin
                        en  <= 1'b1;
                        col <= last_col ? '0 : col + CW'(1);
                    end
                end
                // Blank strobes come from the timer's first cycle, one cycle after the last pixel strobe.
                HBLANK: begin
                    if (timer_first) begin
                        en    <= 1'b1;
                        hsync <= 1'b1;
                    end
                    if (timer_expire) begin
                        row <= row + CW'(1);
                    end
                end
                VBLANK: begin
                    if (timer_first) begin
                        en    <= 1'b1;
                        vsync <= 1'b1;
                    end
                    if (timer_expire) begin
                        row       <= '0;
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase

            if (state_q == IDLE) begin
                if (start) begin
                    stop_q <= stop;
                end
            end else if (state_d == IDLE) begin
                stop_q <= 1'b0;
            end else if (stop) begin
                stop_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer
module tb_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int CW   = 8;
    localparam int MAXS = 600;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          pix_valid  = 1'b0;
    logic [CW-1:0] num_frames = '0;
    logic          pix_ready;
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          busy;
    logic          done;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    bit v      [MAXS];
    bit e_en   [MAXS];
    bit e_hs   [MAXS];
    bit e_vs   [MAXS];
    bit e_done [MAXS];
    bit e_busy [MAXS];
    bit e_ready[MAXS];
    int e_col  [MAXS];
    int e_row  [MAXS];
    int e_fc   [MAXS];
    int model_frames;
    int model_done;

    frame_sequencer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .HBLANK_CYC (HB),
        .VBLANK_CYC (VB),
        .CW         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .num_frames (num_frames),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .en         (en),
        .hsync      (hsync),
        .vsync      (vsync),
        .busy       (busy),
        .done       (done),
        .col        (col),
        .row        (row),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slot s is the cycle whose inputs are sampled on posedge s; start is slot 0.
    // The schedule is derived row by row: W accepted pixels, then a blank interval.
    task automatic build_model(input int nf, input int stop_slot);
        int  t;
        int  f;
        int  cnt;
        int  nb;
        bit  finished;
        for (int k = 0; k < MAXS; k++) begin
            e_en[k] = 0; e_hs[k] = 0; e_vs[k] = 0; e_done[k] = 0;
            e_busy[k] = 0; e_ready[k] = 0; e_col[k] = 0; e_row[k] = 0; e_fc[k] = 0;
        end
        t = 1;
        f = 0;
        finished = 0;
        while (!finished && t < MAXS - 60) begin
            for (int r = 0; r < H; r++) begin
                cnt = 0;
                while (cnt < W && t < MAXS - 60) begin
                    e_ready[t] = 1; e_busy[t] = 1;
                    e_col[t] = cnt; e_row[t] = r; e_fc[t] = f;
                    if (v[t]) begin
                        e_en[t+1] = 1;
                        cnt++;
                    end
                    t++;
                end
                nb = (r < H - 1) ? HB : VB;
                e_en[t+1] = 1;
                if (r < H - 1) e_hs[t+1] = 1;
                else           e_vs[t+1] = 1;
                for (int b = 0; b < nb; b++) begin
                    e_busy[t] = 1; e_col[t] = 0; e_row[t] = r; e_fc[t] = f;
                    t++;
                end
            end
            f++;
            if ((nf != 0 && f == nf) || (stop_slot >= 0 && stop_slot < t)) finished = 1;
        end
        e_done[t] = 1;
        e_busy[t] = 1;
        for (int k = t; k < MAXS; k++) e_fc[k] = f;
        model_frames = f;
        model_done   = t;
    endtask

    task automatic run_case(input int nf, input int stop_slot, input int mode, input int extra,
                            output int done_at, output int pix, output int hs, output int vs,
                            output int dones, output int fc_end);
        for (int t = 0; t < MAXS; t++) begin
            case (mode)
                0:       v[t] = 1;
                1:       v[t] = (t % 2 == 0);
                default: v[t] = ($urandom_range(0, 2) != 0);
            endcase
        end
        build_model(nf, stop_slot);
        done_at = -1; pix = 0; hs = 0; vs = 0; dones = 0;
        num_frames = CW'(nf);
        for (int s = 0; s <= model_done + 3; s++) begin
            start     = (s == 0) || (s == extra);
            stop      = (s == stop_slot);
            pix_valid = v[s];
            @(negedge clk);
            if (s > 0) begin
                chk($sformatf("strobes{en,hs,vs,done,busy,ready}@%0d", s),
                    int'({en, hsync, vsync, done, busy, pix_ready}),
                    int'({e_en[s], e_hs[s], e_vs[s], e_done[s], e_busy[s], e_ready[s]}));
                chk($sformatf("col@%0d", s), int'(col), e_col[s]);
                chk($sformatf("row@%0d", s), int'(row), e_row[s]);
                chk($sformatf("frame_cnt@%0d", s), int'(frame_cnt), e_fc[s] % (1 << CW));
                if (en && !hsync && !vsync) pix++;
                if (hsync) hs++;
                if (vsync) vs++;
                if (done) begin
                    dones++;
                    if (done_at < 0) done_at = s;
                end
            end
            @(posedge clk);
            #1;
        end
        start = 0; stop = 0; pix_valid = 0;
        fc_end = int'(frame_cnt);
    endtask

    typedef struct {
        string name;
        int    nf;
        int    stop_slot;
        int    mode;
        int    extra;
        int    exp_done;
        int    exp_pix;
        int    exp_hs;
        int    exp_vs;
        int    exp_fc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int done_at, pix, hs, vs, dones, fc_end;
        int nf, stop_s, extra;

        vecs[0] = '{"single",     1, -1, 0, -1, 20, 12, 2, 1, 1};
        vecs[1] = '{"backpress",  1, -1, 1, -1, 32, 12, 2, 1, 1};
        vecs[2] = '{"multi",      3, -1, 0, -1, 58, 36, 6, 3, 3};
        vecs[3] = '{"stop_mid",   0,  9, 0, -1, 20, 12, 2, 1, 1};
        vecs[4] = '{"start_stop", 0,  0, 0,  5, 20, 12, 2, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_strobes", int'({en, hsync, vsync, done, busy, pix_ready}), 0);
        chk("reset_counters", int'({col, row, frame_cnt}), 0);
        reset = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_case(vecs[i].nf, vecs[i].stop_slot, vecs[i].mode, vecs[i].extra,
                     done_at, pix, hs, vs, dones, fc_end);
            chk({vecs[i].name, "_done_slot"}, done_at, vecs[i].exp_done);
            chk({vecs[i].name, "_pixels"}, pix, vecs[i].exp_pix);
            chk({vecs[i].name, "_hsync"}, hs, vecs[i].exp_hs);
            chk({vecs[i].name, "_vsync"}, vs, vecs[i].exp_vs);
            chk({vecs[i].name, "_done_count"}, dones, 1);
            chk({vecs[i].name, "_frame_cnt_idle"}, fc_end, vecs[i].exp_fc);
        end

        // Reset in the middle of row 1, column 2.
        num_frames = '0;
        start      = 1;
        pix_valid  = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_reset_col", int'(col), 2);
        chk("pre_reset_row", int'(row), 1);
        reset = 1;
        @(posedge clk);
        #1;
        reset     = 0;
        pix_valid = 0;
        @(negedge clk);
        chk("midreset_strobes", int'({en, hsync, vsync, done, busy, pix_ready}), 0);
        chk("midreset_counters", int'({col, row, frame_cnt}), 0);
        @(posedge clk);
        #1;
        run_case(1, -1, 0, -1, done_at, pix, hs, vs, dones, fc_end);
        chk("after_reset_done_slot", done_at, 20);
        chk("after_reset_pixels", pix, 12);

        for (int i = 0; i < 6; i++) begin
            nf     = int'($urandom_range(0, 3));
            stop_s = -1;
            if (nf == 0 || $urandom_range(0, 1) == 1) stop_s = int'($urandom_range(0, 70));
            extra  = int'($urandom_range(1, 15));
            run_case(nf, stop_s, 2, extra, done_at, pix, hs, vs, dones, fc_end);
            chk($sformatf("rand%0d_done_slot", i), done_at, model_done);
            chk($sformatf("rand%0d_pixels", i), pix, W * H * model_frames);
            chk($sformatf("rand%0d_hsync", i), hs, (H - 1) * model_frames);
            chk($sformatf("rand%0d_vsync", i), vs, model_frames);
            chk($sformatf("rand%0d_done_count", i), dones, 1);
            chk($sformatf("rand%0d_frame_cnt_idle", i), fc_end, model_frames);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
